// File: rtl/branch_pred_ctrl_pkg.sv
// Shared control-flow encodings for the branch predictor and the ID/EX control path.
package branch_pred_ctrl_pkg;

  typedef enum logic [1:0] {
    JT_NONE   = 2'b00,
    JT_JAL    = 2'b01,
    JT_JALR   = 2'b10,
    JT_BRANCH = 2'b11
  } j_type_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_ID_TGT = 2'b01,
    PC_EX_TGT = 2'b10,
    PC_EX_SEQ = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_e;

  localparam logic [1:0] BHT_RESET = BHT_WNT;

endpackage

// File: rtl/branch_pred_ctrl_bht_sat2.sv
// One 2-bit saturating branch-history counter; resets to weak not-taken.
module bht_sat2
  import branch_pred_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BHT_RESET;
    end else if (inc && (state != BHT_ST)) begin
      state <= state + 2'd1;
    end else if (dec && (state != BHT_SNT)) begin
      state <= state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Control-flow sequencer: BHT prediction in ID, jump/branch resolution in EX, PC select and flushes.
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             id_is_branch,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [1:0]       ex_j_type,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  output logic [1:0]       pc_sel,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  localparam int ENTRIES = 2 ** IDX_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       bht_q [ENTRIES];
  logic             resolve;
  logic             mispred;
  logic             jump;
  logic             pred;
  logic             unused_pc;

  assign id_idx    = id_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign unused_pc = ^{id_pc[PC_W-1:IDX_W+2], id_pc[1:0], ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  assign resolve = ex_valid && (ex_j_type == JT_BRANCH);
  assign mispred = resolve && (ex_taken != ex_pred_taken);
  assign jump    = ex_valid && ((ex_j_type == JT_JAL) || (ex_j_type == JT_JALR));

  // Only conditional branches train; the write is one-hot on the EX index.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_bht
    logic hit;
    assign hit = resolve && (ex_idx == IDX_W'(g));
    bht_sat2 u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit && ex_taken),
      .dec   (hit && !ex_taken),
      .state (bht_q[g])
    );
  end

  // The read uses the registered table, so a same-cycle EX update is not visible to ID.
  assign pred       = rst && id_is_branch && bp_en && bht_q[id_idx][1];
  assign pred_taken = pred;

  always_comb begin
    pc_sel   = PC_SEQ;
    flush_if = 1'b0;
    flush_id = 1'b0;
    if (!rst) begin
      pc_sel   = PC_SEQ;
    end else if (jump) begin
      pc_sel   = PC_EX_TGT;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (mispred) begin
      pc_sel   = ex_taken ? PC_EX_TGT : PC_EX_SEQ;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (pred) begin
      pc_sel   = PC_ID_TGT;
      flush_if = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve) branch_cnt  <= sat_inc(branch_cnt);
      if (mispred) mispred_cnt <= sat_inc(mispred_cnt);
    end
  end

endmodule
